lfsr_seq: RTL and testbench

LFSR_SEQ -- requirements
Module: lfsr_seq

---
 rtl/lfsr_seq.sv | 114 +++++++++++
 tb/tb_lfsr_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq.sv
// Fibonacci LFSR with seed load, wrap detection against a reference seed and
// recovery from the all-zero lock-up state. Q[1] is the MSB and receives feedback.
module lfsr_seq #(
    parameter int unsigned N = 3,
    parameter logic [N-1:0] RESET_SEED = N'(1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] seed,
    output logic [1:N]   Q,
    output logic [N-1:0] count,
    output logic         wrap,
    output logic         lockup_err
);

    localparam logic [N-1:0] ONE       = N'(1);
    localparam logic [N-1:0] INIT_SEED = (RESET_SEED == '0) ? ONE : RESET_SEED;

    if (N < 3 || N > 16) begin : g_bad_width
        $error("lfsr_seq: N must be in 3..16");
    end

    // Tap t refers to Q[t], which lives at bit N-t of the internal state.
    function automatic logic [N-1:0] bit_at(input int unsigned t);
        return ONE << (N - t);
    endfunction

    function automatic logic [N-1:0] tap_mask();
        case (N)
            3:       return bit_at(3)  | bit_at(2);
            4:       return bit_at(4)  | bit_at(3);
            5:       return bit_at(5)  | bit_at(3);
            6:       return bit_at(6)  | bit_at(5);
            7:       return bit_at(7)  | bit_at(6);
            8:       return bit_at(8)  | bit_at(6)  | bit_at(5) | bit_at(4);
            9:       return bit_at(9)  | bit_at(5);
            10:      return bit_at(10) | bit_at(7);
            11:      return bit_at(11) | bit_at(9);
            12:      return bit_at(12) | bit_at(6)  | bit_at(4) | bit_at(1);
            13:      return bit_at(13) | bit_at(4)  | bit_at(3) | bit_at(1);
            14:      return bit_at(14) | bit_at(5)  | bit_at(3) | bit_at(1);
            15:      return bit_at(15) | bit_at(14);
            16:      return bit_at(16) | bit_at(15) | bit_at(13) | bit_at(4);
            default: return ONE;
        endcase
    endfunction

    localparam logic [N-1:0] TAPS = tap_mask();

    logic [N-1:0] state;
    logic [N-1:0] state_nxt;
    logic [N-1:0] ref_seed;
    logic [N-1:0] ref_nxt;
    logic [N-1:0] count_nxt;
    logic [N-1:0] step;
    logic         fb;
    logic         wrap_nxt;
    logic         lockup_nxt;

    assign fb   = ^(state & TAPS);
    assign step = {fb, state[N-1:1]};
    assign Q    = state;

    // Priority below reset: load, lock-up recovery, enabled step, hold.
    always_comb begin
        state_nxt  = state;
        ref_nxt    = ref_seed;
        count_nxt  = count;
        wrap_nxt   = 1'b0;
        lockup_nxt = 1'b0;
        if (load) begin
            count_nxt = '0;
            if (seed == '0) begin
                state_nxt  = ONE;
                ref_nxt    = ONE;
                lockup_nxt = 1'b1;
            end else begin
                state_nxt = seed;
                ref_nxt   = seed;
            end
        end else if (state == '0) begin
            state_nxt  = ref_seed;
            count_nxt  = '0;
            lockup_nxt = 1'b1;
        end else if (en) begin
            state_nxt = step;
            if (step == ref_seed) begin
                count_nxt = '0;
                wrap_nxt  = 1'b1;
            end else begin
                count_nxt = count + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= INIT_SEED;
            ref_seed   <= INIT_SEED;
            count      <= '0;
            wrap       <= 1'b0;
            lockup_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            ref_seed   <= ref_nxt;
            count      <= count_nxt;
            wrap       <= wrap_nxt;
            lockup_err <= lockup_nxt;
        end
    end

endmodule

// File: tb/tb_lfsr_seq.sv
// Self-checking bench for lfsr_seq: directed scenarios, randomized run against
// an integer reference model, and a full-period sweep for every width 3..16.
module tb_lfsr_seq;

    localparam int unsigned N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         en;
    logic         load;
    logic [N-1:0] seed;
    logic [N-1:0] q;
    logic [N-1:0] count;
    logic         wrap;
    logic         lockup_err;

    logic [4:0]   zq;
    logic [4:0]   zcount;
    logic         zwrap;
    logic         zlock;

    logic sweep_rst_n = 1'b1;
    logic sweep_en    = 1'b0;

    int checks = 0;
    int errors = 0;

    lfsr_seq #(.N(N), .RESET_SEED(3'd1)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed(seed),
        .Q(q), .count(count), .wrap(wrap), .lockup_err(lockup_err)
    );

    lfsr_seq #(.N(5), .RESET_SEED(5'd0)) dz (
        .clk(clk), .reset_n(reset_n), .en(1'b0), .load(1'b0), .seed(5'd0),
        .Q(zq), .count(zcount), .wrap(zwrap), .lockup_err(zlock)
    );

    // Reference: state as an integer, MSB = Q[1]; tap t has weight 2^(n-t).
    function automatic int tw(int n, int t);
        return 1 << (n - t);
    endfunction

    function automatic int taps_for(int n);
        case (n)
            3:       return tw(n, 3)  | tw(n, 2);
            4:       return tw(n, 4)  | tw(n, 3);
            5:       return tw(n, 5)  | tw(n, 3);
            6:       return tw(n, 6)  | tw(n, 5);
            7:       return tw(n, 7)  | tw(n, 6);
            8:       return tw(n, 8)  | tw(n, 6)  | tw(n, 5) | tw(n, 4);
            9:       return tw(n, 9)  | tw(n, 5);
            10:      return tw(n, 10) | tw(n, 7);
            11:      return tw(n, 11) | tw(n, 9);
            12:      return tw(n, 12) | tw(n, 6)  | tw(n, 4) | tw(n, 1);
            13:      return tw(n, 13) | tw(n, 4)  | tw(n, 3) | tw(n, 1);
            14:      return tw(n, 14) | tw(n, 5)  | tw(n, 3) | tw(n, 1);
            15:      return tw(n, 15) | tw(n, 14);
            default: return tw(n, 16) | tw(n, 15) | tw(n, 13) | tw(n, 4);
        endcase
    endfunction

    function automatic int lfsr_next(int n, int s);
        int fb;
        fb = $countones(s & taps_for(n)) % 2;
        return (s >> 1) | (fb << (n - 1));
    endfunction

    wire [31:0] sw_distinct [3:16];
    wire [31:0] sw_repeats  [3:16];
    wire [31:0] sw_bad      [3:16];
    wire [31:0] sw_mism     [3:16];
    wire [31:0] sw_wraps    [3:16];
    wire [31:0] sw_wrap_at  [3:16];

    // One free-running instance per width, each with its own period tracker.
    for (genvar g = 3; g <= 16; g++) begin : g_sw
        localparam int PER = (1 << g) - 1;
        logic [g-1:0] sq;
        logic [g-1:0] scount;
        logic         swrap;
        logic         slock;
        bit           seen [0:PER];
        int steps = 0, distinct = 0, repeats = 0, bad = 0;
        int mism = 0, wraps = 0, wrap_at = 0, exp_s = 1;

        lfsr_seq #(.N(g)) u (
            .clk(clk), .reset_n(sweep_rst_n), .en(sweep_en), .load(1'b0),
            .seed({g{1'b0}}), .Q(sq), .count(scount), .wrap(swrap), .lockup_err(slock)
        );

        always begin
            @(posedge clk);
            #1;
            if (!sweep_rst_n) begin
                for (int i = 0; i <= PER; i++) seen[i] = 1'b0;
                seen[1] = 1'b1;
                steps = 0; distinct = 1; repeats = 0; bad = 0;
                mism = 0; wraps = 0; wrap_at = 0; exp_s = 1;
            end else if (sweep_en && steps < PER) begin
                steps++;
                exp_s = lfsr_next(g, exp_s);
                if (32'(sq) != exp_s) mism++;
                if (32'(scount) != (steps % PER)) mism++;
                if (sq == '0 || slock) bad++;
                if (swrap) begin
                    wraps++;
                    wrap_at = steps;
                end
                if (seen[sq]) begin
                    if (steps < PER) repeats++;
                end else begin
                    distinct++;
                end
                seen[sq] = 1'b1;
            end
        end

        assign sw_distinct[g] = 32'(distinct);
        assign sw_repeats[g]  = 32'(repeats);
        assign sw_bad[g]      = 32'(bad);
        assign sw_mism[g]     = 32'(mism);
        assign sw_wraps[g]    = 32'(wraps);
        assign sw_wrap_at[g]  = 32'(wrap_at);
    end

    task automatic test_reset;
        reset_n = 1'b0; load = 1'b1; en = 1'b1; seed = 3'd5;
        @(negedge clk);
        checks++; if (q !== 3'd1) begin errors++; $display("FAIL reset_q got %0d want 1", q); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %0b want 0", wrap); end
        checks++; if (lockup_err !== 1'b0) begin errors++; $display("FAIL reset_lockup got %0b want 0", lockup_err); end
        checks++; if (zq !== 5'd1) begin errors++; $display("FAIL reset_zero_seed_q got %0d want 1", zq); end
        checks++; if ({zcount, zwrap, zlock} !== 7'd0) begin
            errors++; $display("FAIL reset_zero_seed_outs got %0d/%0b/%0b want 0/0/0", zcount, zwrap, zlock);
        end
        reset_n = 1'b1; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_run;
        int exp_q [7];
        int exp_c [7];
        exp_q = '{4, 2, 5, 6, 7, 3, 1};
        exp_c = '{1, 2, 3, 4, 5, 6, 0};
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++; if (q !== 3'(exp_q[k])) begin errors++; $display("FAIL run_q[%0d] got %0d want %0d", k, q, exp_q[k]); end
            checks++; if (count !== 3'(exp_c[k])) begin errors++; $display("FAIL run_count[%0d] got %0d want %0d", k, count, exp_c[k]); end
            checks++; if (wrap !== (k == 6)) begin errors++; $display("FAIL run_wrap[%0d] got %0b want %0b", k, wrap, k == 6); end
        end
        en = 1'b0;
    endtask

    task automatic test_seed_load;
        int exp_q [7];
        exp_q = '{6, 7, 3, 1, 4, 2, 5};
        load = 1'b1; seed = 3'd5; en = 1'b0;
        @(negedge clk);
        checks++; if (q !== 3'd5 || count !== 3'd0) begin errors++; $display("FAIL load_q_count got %0d/%0d want 5/0", q, count); end
        checks++; if (wrap !== 1'b0 || lockup_err !== 1'b0) begin errors++; $display("FAIL load_pulses got %0b/%0b want 0/0", wrap, lockup_err); end
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++; if (q !== 3'(exp_q[k])) begin errors++; $display("FAIL load_seq_q[%0d] got %0d want %0d", k, q, exp_q[k]); end
            checks++; if (wrap !== (k == 6)) begin errors++; $display("FAIL load_seq_wrap[%0d] got %0b want %0b", k, wrap, k == 6); end
        end
        load = 1'b1; seed = 3'd3; en = 1'b1;
        @(negedge clk);
        checks++; if (q !== 3'd3 || count !== 3'd0) begin errors++; $display("FAIL load_with_en got %0d/%0d want 3/0", q, count); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load_with_en_wrap got %0b want 0", wrap); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_zero_seed;
        load = 1'b1; seed = 3'd0; en = 1'b1;
        @(negedge clk);
        checks++; if (q !== 3'd1 || count !== 3'd0) begin errors++; $display("FAIL zero_seed_q got %0d/%0d want 1/0", q, count); end
        checks++; if (lockup_err !== 1'b1 || wrap !== 1'b0) begin errors++; $display("FAIL zero_seed_pulse got %0b/%0b want 1/0", lockup_err, wrap); end
        load = 1'b0;
        @(negedge clk);
        checks++; if (q !== 3'd4 || count !== 3'd1) begin errors++; $display("FAIL zero_seed_next got %0d/%0d want 4/1", q, count); end
        checks++; if (lockup_err !== 1'b0) begin errors++; $display("FAIL zero_seed_pulse_len got %0b want 0", lockup_err); end
        en = 1'b0;
    endtask

    task automatic test_upset;
        load = 1'b1; seed = 3'd5; en = 1'b0;
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        repeat (2) @(negedge clk);
        force dut.state = '0;
        @(negedge clk);
        checks++; if (lockup_err !== 1'b1) begin errors++; $display("FAIL upset_lockup got %0b want 1", lockup_err); end
        checks++; if (count !== 3'd0 || wrap !== 1'b0) begin errors++; $display("FAIL upset_count_wrap got %0d/%0b want 0/0", count, wrap); end
        release dut.state;
        en = 1'b0;
        @(negedge clk);
        checks++; if (q !== 3'd5 || count !== 3'd0) begin errors++; $display("FAIL upset_restore got %0d/%0d want 5/0", q, count); end
    endtask

    task automatic test_hold;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; en = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (q !== 3'd5 || count !== 3'd3) begin errors++; $display("FAIL hold[%0d] got %0d/%0d want 5/3", k, q, count); end
            checks++; if (wrap !== 1'b0 || lockup_err !== 1'b0) begin errors++; $display("FAIL hold_pulses[%0d] got %0b/%0b want 0/0", k, wrap, lockup_err); end
        end
        en = 1'b1;
        @(negedge clk);
        checks++; if (q !== 3'd6 || count !== 3'd4) begin errors++; $display("FAIL hold_resume got %0d/%0d want 6/4", q, count); end
        reset_n = 1'b0; load = 1'b1; seed = 3'd6;
        @(negedge clk);
        checks++; if (q !== 3'd1 || count !== 3'd0) begin errors++; $display("FAIL midrun_reset got %0d/%0d want 1/0", q, count); end
        checks++; if (wrap !== 1'b0 || lockup_err !== 1'b0) begin errors++; $display("FAIL midrun_reset_pulses got %0b/%0b want 0/0", wrap, lockup_err); end
        reset_n = 1'b1; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_random;
        int mq, mref, mcnt;
        bit mw, ml;
        reset_n = 1'b0; load = 1'b0; en = 1'b0;
        @(negedge clk);
        mq = 1; mref = 1; mcnt = 0;
        for (int k = 0; k < 400; k++) begin
            reset_n = ($urandom_range(0, 39) != 0);
            load    = ($urandom_range(0, 7) == 0);
            seed    = 3'($urandom_range(0, 7));
            en      = ($urandom_range(0, 3) != 0);
            mw = 1'b0; ml = 1'b0;
            if (!reset_n) begin
                mq = 1; mref = 1; mcnt = 0;
            end else if (load) begin
                mq = (seed == 3'd0) ? 1 : 32'(seed);
                ml = (seed == 3'd0);
                mref = mq; mcnt = 0;
            end else if (mq == 0) begin
                mq = mref; mcnt = 0; ml = 1'b1;
            end else if (en) begin
                mq = lfsr_next(N, mq);
                if (mq == mref) begin mw = 1'b1; mcnt = 0; end
                else mcnt++;
            end
            @(negedge clk);
            checks++; if (q !== 3'(mq)) begin errors++; $display("FAIL rand_q[%0d] got %0d want %0d", k, q, mq); end
            checks++; if (count !== 3'(mcnt)) begin errors++; $display("FAIL rand_count[%0d] got %0d want %0d", k, count, mcnt); end
            checks++; if (wrap !== mw) begin errors++; $display("FAIL rand_wrap[%0d] got %0b want %0b", k, wrap, mw); end
            checks++; if (lockup_err !== ml) begin errors++; $display("FAIL rand_lockup[%0d] got %0b want %0b", k, lockup_err, ml); end
        end
        reset_n = 1'b1; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_sweep;
        sweep_rst_n = 1'b0; sweep_en = 1'b0;
        @(negedge clk);
        sweep_rst_n = 1'b1; sweep_en = 1'b1;
        repeat (65535) @(negedge clk);
        sweep_en = 1'b0;
        @(negedge clk);
        for (int g = 3; g <= 16; g++) begin
            checks++; if (sw_distinct[g] !== 32'((1 << g) - 1)) begin errors++; $display("FAIL sweep_distinct N=%0d got %0d want %0d", g, sw_distinct[g], (1 << g) - 1); end
            checks++; if (sw_repeats[g] !== 32'd0) begin errors++; $display("FAIL sweep_repeats N=%0d got %0d want 0", g, sw_repeats[g]); end
            checks++; if (sw_bad[g] !== 32'd0) begin errors++; $display("FAIL sweep_zero_or_lockup N=%0d got %0d want 0", g, sw_bad[g]); end
            checks++; if (sw_mism[g] !== 32'd0) begin errors++; $display("FAIL sweep_model N=%0d got %0d want 0", g, sw_mism[g]); end
            checks++; if (sw_wraps[g] !== 32'd1) begin errors++; $display("FAIL sweep_wraps N=%0d got %0d want 1", g, sw_wraps[g]); end
            checks++; if (sw_wrap_at[g] !== 32'((1 << g) - 1)) begin errors++; $display("FAIL sweep_wrap_at N=%0d got %0d want %0d", g, sw_wrap_at[g], (1 << g) - 1); end
        end
    endtask

    initial begin
        reset_n = 1'b1; en = 1'b0; load = 1'b0; seed = '0;
        test_reset();
        test_run();
        test_seed_load();
        test_zero_seed();
        test_upset();
        test_hold();
        test_random();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
